// File: rtl/bomb_pkg.sv
// Shared types and widths for the bomb scheduler slice.
// The chain-reaction option is selected with BOMB_CHAIN_REACTION_EN (see bomb_scheduler).
package bomb_pkg;

  typedef enum logic [1:0] {
    FREE_ST    = 2'd0,
    FUSE_ST    = 2'd1,
    EXPLODE_ST = 2'd2
  } slot_state_t;

  localparam int TILE_W      = 5;
  localparam int COORD_W     = 11;
  localparam int CNT_W       = 8;
  localparam int CHAIN_RANGE = 2;

  // True when two tile indices are within blast reach of each other
  function automatic logic tile_near(input logic [TILE_W-1:0] a, input logic [TILE_W-1:0] b);
    logic [TILE_W-1:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return (d <= TILE_W'(CHAIN_RANGE));
  endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: FREE/FUSE/EXPLODE FSM, frame counter, tile latch and
// registered screen coordinates (one cycle behind the state register).
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int FUSE_FRAMES    = 90,
  parameter int EXPLODE_FRAMES = 30,
  parameter int TILE_SIZE      = 32,
  parameter int OFFSET_X       = 0,
  parameter int OFFSET_Y       = 0,
  parameter int HIDDEN_XY      = 1000
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic                      load,
  input  logic [TILE_W-1:0]         load_col,
  input  logic [TILE_W-1:0]         load_row,
  input  logic                      trigger,
  output slot_state_t               state,
  output logic [TILE_W-1:0]         col,
  output logic [TILE_W-1:0]         row,
  output logic                      exist,
  output logic                      exploded,
  output logic signed [COORD_W-1:0] top_left_x,
  output logic signed [COORD_W-1:0] top_left_y
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  slot_state_t                state_r, state_s;
  logic [CNT_W-1:0]           cnt_r, cnt_s;
  logic [TILE_W-1:0]          col_r, row_r, col_s, row_s;
  logic signed [COORD_W-1:0]  x_s, y_s;

  // Next state: load wins in FREE, trigger or expiring fuse enters EXPLODE once
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    col_s   = col_r;
    row_s   = row_r;
    case (state_r)
      FREE_ST: begin
        if (load) begin
          state_s = FUSE_ST;
          cnt_s   = CNT_W'(FUSE_FRAMES);
          col_s   = load_col;
          row_s   = load_row;
        end else begin
          state_s = FREE_ST;
        end
      end
      FUSE_ST: begin
        if (trigger || (startOfFrame && (cnt_r == CNT_ONE))) begin
          state_s = EXPLODE_ST;
          cnt_s   = CNT_W'(EXPLODE_FRAMES);
        end else if (startOfFrame) begin
          cnt_s = cnt_r - CNT_ONE;
        end else begin
          cnt_s = cnt_r;
        end
      end
      EXPLODE_ST: begin
        if (startOfFrame && (cnt_r == CNT_ONE)) begin
          state_s = FREE_ST;
          cnt_s   = '0;
        end else if (startOfFrame) begin
          cnt_s = cnt_r - CNT_ONE;
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = FREE_ST;
        cnt_s   = '0;
      end
    endcase
  end

  // Tile to pixel mapping, wrapped to the 11-bit signed coordinate space
  always_comb begin
    x_s = COORD_W'(OFFSET_X) + COORD_W'(col_r) * COORD_W'(TILE_SIZE);
    y_s = COORD_W'(OFFSET_Y) + COORD_W'(row_r) * COORD_W'(TILE_SIZE);
  end

  // Slot state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r <= FREE_ST;
      cnt_r   <= '0;
      col_r   <= '0;
      row_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      col_r   <= col_s;
      row_r   <= row_s;
    end
  end

  // Display outputs follow the state register by one cycle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      exist      <= 1'b0;
      exploded   <= 1'b0;
      top_left_x <= COORD_W'(HIDDEN_XY);
      top_left_y <= COORD_W'(HIDDEN_XY);
    end else begin
      exist      <= (state_r == FUSE_ST);
      exploded   <= (state_r == EXPLODE_ST);
      top_left_x <= (state_r == FREE_ST) ? COORD_W'(HIDDEN_XY) : x_s;
      top_left_y <= (state_r == FREE_ST) ? COORD_W'(HIDDEN_XY) : y_s;
    end
  end

  assign state = state_r;
  assign col   = col_r;
  assign row   = row_r;

endmodule

// File: rtl/bomb_scheduler.sv
// Bomb slot pool: allocator, ack/nack, occupancy count and slot array.
// Define BOMB_CHAIN_REACTION_EN to let explosions ignite nearby fused bombs.
module bomb_scheduler
  import bomb_pkg::*;
#(
  parameter int NUM_BOMBS      = 4,
  parameter int FUSE_FRAMES    = 90,
  parameter int EXPLODE_FRAMES = 30,
  parameter int TILE_SIZE      = 32,
  parameter int OFFSET_X       = 0,
  parameter int OFFSET_Y       = 0,
  parameter int HIDDEN_XY      = 1000
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic                           place_req,
  input  logic [TILE_W-1:0]              place_col,
  input  logic [TILE_W-1:0]              place_row,
  output logic                           place_ack,
  output logic                           place_nack,
  input  logic [NUM_BOMBS-1:0]           detonate,
  output logic [NUM_BOMBS-1:0]           bomb_exist,
  output logic [NUM_BOMBS-1:0]           bomb_exploded,
  output logic [NUM_BOMBS*COORD_W-1:0]   topLeftX_out,
  output logic [NUM_BOMBS*COORD_W-1:0]   topLeftY_out,
  output logic [3:0]                     active_count
);

  slot_state_t          slot_state_s [NUM_BOMBS];
  logic [TILE_W-1:0]    slot_col_s   [NUM_BOMBS];
  logic [TILE_W-1:0]    slot_row_s   [NUM_BOMBS];
  logic [NUM_BOMBS-1:0] pick_s, load_s, trigger_s, chain_s;
  logic                 free_found_s, dup_s, accept_s;
  logic [3:0]           busy_cnt_s;

  // Allocator: lowest FREE slot wins; duplicates are checked against live slots only
  always_comb begin
    pick_s       = '0;
    free_found_s = 1'b0;
    dup_s        = 1'b0;
    busy_cnt_s   = 4'd0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      pick_s[i]    = (slot_state_s[i] == FREE_ST) & ~free_found_s;
      free_found_s = free_found_s | (slot_state_s[i] == FREE_ST);
      dup_s        = dup_s | ((slot_state_s[i] != FREE_ST) &
                              (slot_col_s[i] == place_col) & (slot_row_s[i] == place_row));
      busy_cnt_s   = busy_cnt_s + 4'((slot_state_s[i] != FREE_ST));
    end
    accept_s = place_req & free_found_s & ~dup_s;
    load_s   = accept_s ? pick_s : '0;
  end

`ifdef BOMB_CHAIN_REACTION_EN
  logic [NUM_BOMBS-1:0] was_explode_r, entered_s;

  // Remembers which slots were already exploding, to spot fresh entries
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      was_explode_r <= '0;
    end else begin
      for (int i = 0; i < NUM_BOMBS; i++) was_explode_r[i] <= (slot_state_s[i] == EXPLODE_ST);
    end
  end

  // A fresh explosion ignites fused neighbours on the same row or column, one hop per cycle
  always_comb begin
    chain_s = '0;
    for (int i = 0; i < NUM_BOMBS; i++) entered_s[i] = (slot_state_s[i] == EXPLODE_ST) & ~was_explode_r[i];
    for (int j = 0; j < NUM_BOMBS; j++) begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        chain_s[j] = chain_s[j] | (entered_s[i] & (slot_state_s[j] == FUSE_ST) &
                     (((slot_row_s[i] == slot_row_s[j]) & tile_near(slot_col_s[i], slot_col_s[j])) |
                      ((slot_col_s[i] == slot_col_s[j]) & tile_near(slot_row_s[i], slot_row_s[j]))));
      end
    end
  end
`else
  assign chain_s = '0;
`endif

  assign trigger_s = detonate | chain_s;

  // Handshake and occupancy registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      place_ack    <= 1'b0;
      place_nack   <= 1'b0;
      active_count <= 4'd0;
    end else begin
      place_ack    <= accept_s;
      place_nack   <= place_req & ~accept_s;
      active_count <= busy_cnt_s;
    end
  end

  for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_slot
    bomb_slot #(
      .FUSE_FRAMES   (FUSE_FRAMES),
      .EXPLODE_FRAMES(EXPLODE_FRAMES),
      .TILE_SIZE     (TILE_SIZE),
      .OFFSET_X      (OFFSET_X),
      .OFFSET_Y      (OFFSET_Y),
      .HIDDEN_XY     (HIDDEN_XY)
    ) u_slot (
      .clk         (clk),
      .resetN      (resetN),
      .startOfFrame(startOfFrame),
      .load        (load_s[g]),
      .load_col    (place_col),
      .load_row    (place_row),
      .trigger     (trigger_s[g]),
      .state       (slot_state_s[g]),
      .col         (slot_col_s[g]),
      .row         (slot_row_s[g]),
      .exist       (bomb_exist[g]),
      .exploded    (bomb_exploded[g]),
      .top_left_x  (topLeftX_out[COORD_W*g +: COORD_W]),
      .top_left_y  (topLeftY_out[COORD_W*g +: COORD_W])
    );
  end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler: placement replies go through a scoreboard
// queue; slot flags, coordinates and counts are checked against fixed expectations.
module tb_bomb_scheduler;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        place_req;
  logic [4:0]  place_col, place_row;
  logic        place_ack, place_nack;
  logic [3:0]  detonate;
  logic [3:0]  bomb_exist, bomb_exploded;
  logic [43:0] topLeftX_out, topLeftY_out;
  logic [3:0]  active_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  bomb_scheduler dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .place_req(place_req), .place_col(place_col), .place_row(place_row),
    .place_ack(place_ack), .place_nack(place_nack), .detonate(detonate),
    .bomb_exist(bomb_exist), .bomb_exploded(bomb_exploded),
    .topLeftX_out(topLeftX_out), .topLeftY_out(topLeftY_out),
    .active_count(active_count)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] xof(input int i);
    return topLeftX_out[11*i +: 11];
  endfunction

  function automatic logic [10:0] yof(input int i);
    return topLeftY_out[11*i +: 11];
  endfunction

  // Scoreboard: every ack/nack pulse must match the oldest outstanding request
  always @(negedge clk) begin
    bit e;
    if (place_ack || place_nack) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected ack=%0b nack=%0b required=none", place_ack, place_nack);
      end else begin
        e = exp_q.pop_front();
        if ({place_ack, place_nack} !== {e, ~e}) begin
          n_fail++;
          $display("FAIL resp got ack=%0b nack=%0b required ack=%0b nack=%0b", place_ack, place_nack, e, ~e);
        end
      end
    end
  end

  task automatic cyc(input logic sof, input logic req, input logic [4:0] c, input logic [4:0] r,
                     input logic [3:0] det, input logic exp_ack);
    @(negedge clk);
    startOfFrame = sof; place_req = req; place_col = c; place_row = r; detonate = det;
    if (req) exp_q.push_back(exp_ack);
    @(posedge clk);
    #1;
    startOfFrame = 1'b0; place_req = 1'b0; detonate = 4'b0000;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 4'b0000, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 5'd0, 5'd0, 4'b0000, 1'b0);
  endtask

  task automatic place(input logic [4:0] c, input logic [4:0] r, input logic exp_ack);
    cyc(1'b0, 1'b1, c, r, 4'b0000, exp_ack);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0; exp_q.delete();
    startOfFrame = 1'b0; place_req = 1'b0; detonate = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    logic [43:0] hid;
    hid = {4{11'd1000}};
    resetN = 1'b0; startOfFrame = 1'b0; place_req = 1'b0; place_col = 5'd0; place_row = 5'd0; detonate = 4'b0000;
    #12;
    n_checks++; if ({place_ack, place_nack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks got=%b required=00", {place_ack, place_nack}); end
    n_checks++; if ({bomb_exist, bomb_exploded} !== 8'h00) begin n_fail++; $display("FAIL reset_flags got=%h required=00", {bomb_exist, bomb_exploded}); end
    n_checks++; if (topLeftX_out !== hid || topLeftY_out !== hid) begin n_fail++; $display("FAIL reset_coords got x=%h y=%h required=%h", topLeftX_out, topLeftY_out, hid); end
    n_checks++; if (active_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d required=0", active_count); end
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_place_and_expire();
    do_reset();
    place(5'd3, 5'd2, 1'b1);
    idle();
    n_checks++; if (bomb_exist !== 4'b0001 || bomb_exploded !== 4'b0000) begin n_fail++; $display("FAIL place_flags got exist=%b expl=%b required 0001/0000", bomb_exist, bomb_exploded); end
    n_checks++; if (xof(0) !== 11'd96 || yof(0) !== 11'd64) begin n_fail++; $display("FAIL place_xy got %0d,%0d required 96,64", xof(0), yof(0)); end
    n_checks++; if (xof(1) !== 11'd1000) begin n_fail++; $display("FAIL place_hidden got %0d required 1000", xof(1)); end
    n_checks++; if (active_count !== 4'd1) begin n_fail++; $display("FAIL place_count got=%0d required=1", active_count); end
    frames(90);
    n_checks++; if (bomb_exist !== 4'b0001) begin n_fail++; $display("FAIL fuse_latency got exist=%b required=0001", bomb_exist); end
    idle();
    n_checks++; if (bomb_exist !== 4'b0000 || bomb_exploded !== 4'b0001) begin n_fail++; $display("FAIL expire_flags got exist=%b expl=%b required 0000/0001", bomb_exist, bomb_exploded); end
    n_checks++; if (xof(0) !== 11'd96) begin n_fail++; $display("FAIL explode_x got %0d required 96", xof(0)); end
    frames(29);
    n_checks++; if (bomb_exploded !== 4'b0001) begin n_fail++; $display("FAIL explode_hold got=%b required=0001", bomb_exploded); end
    frames(1);
    idle();
    n_checks++; if (bomb_exploded !== 4'b0000 || xof(0) !== 11'd1000 || yof(0) !== 11'd1000) begin n_fail++; $display("FAIL freed got expl=%b x=%0d y=%0d required 0000,1000,1000", bomb_exploded, xof(0), yof(0)); end
    n_checks++; if (active_count !== 4'd0) begin n_fail++; $display("FAIL freed_count got=%0d required=0", active_count); end
  endtask

  task automatic test_full_and_dup();
    do_reset();
    for (int i = 1; i <= 4; i++) place(5'(i), 5'd1, 1'b1);
    place(5'd7, 5'd7, 1'b0);
    idle();
    n_checks++; if (bomb_exist !== 4'b1111 || active_count !== 4'd4) begin n_fail++; $display("FAIL full got exist=%b count=%0d required 1111/4", bomb_exist, active_count); end
    n_checks++; if (xof(3) !== 11'd128 || yof(3) !== 11'd32) begin n_fail++; $display("FAIL full_xy3 got %0d,%0d required 128,32", xof(3), yof(3)); end
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 4'b1000, 1'b0);
    idle();
    n_checks++; if (bomb_exploded !== 4'b1000 || bomb_exist !== 4'b0111) begin n_fail++; $display("FAIL det3 got expl=%b exist=%b required 1000/0111", bomb_exploded, bomb_exist); end
    frames(30);
    place(5'd1, 5'd1, 1'b0);
    n_checks++; if (active_count !== 4'd3 || bomb_exploded !== 4'b0000) begin n_fail++; $display("FAIL slot3_freed got count=%0d expl=%b required 3/0000", active_count, bomb_exploded); end
    place(5'd4, 5'd1, 1'b1);
    idle();
    n_checks++; if (bomb_exist !== 4'b1111 || active_count !== 4'd4) begin n_fail++; $display("FAIL refill got exist=%b count=%0d required 1111/4", bomb_exist, active_count); end
  endtask

  task automatic test_detonate();
    do_reset();
    place(5'd1, 5'd1, 1'b1);
    place(5'd5, 5'd5, 1'b1);
    frames(50);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 4'b0010, 1'b0);
    idle();
    n_checks++; if (bomb_exploded !== 4'b0010 || bomb_exist !== 4'b0001) begin n_fail++; $display("FAIL det1 got expl=%b exist=%b required 0010/0001", bomb_exploded, bomb_exist); end
    frames(30);
    idle();
    n_checks++; if (bomb_exist !== 4'b0001 || bomb_exploded !== 4'b0000 || active_count !== 4'd1) begin n_fail++; $display("FAIL det1_freed got exist=%b expl=%b count=%0d required 0001/0000/1", bomb_exist, bomb_exploded, active_count); end
    frames(9);
    idle();
    n_checks++; if (bomb_exist !== 4'b0001) begin n_fail++; $display("FAIL slot0_undisturbed got exist=%b required=0001", bomb_exist); end
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 4'b0011, 1'b0);
    idle();
    n_checks++; if (bomb_exploded !== 4'b0001 || bomb_exist !== 4'b0000) begin n_fail++; $display("FAIL det_on_expiry got expl=%b exist=%b required 0001/0000", bomb_exploded, bomb_exist); end
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 4'b0001, 1'b0);
    frames(29);
    idle();
    n_checks++; if (bomb_exploded !== 4'b0001) begin n_fail++; $display("FAIL det_explode_len got=%b required=0001", bomb_exploded); end
    frames(1);
    idle();
    n_checks++; if (bomb_exploded !== 4'b0000 || active_count !== 4'd0) begin n_fail++; $display("FAIL det_final got expl=%b count=%0d required 0000/0", bomb_exploded, active_count); end
  endtask

  task automatic test_place_on_expiry();
    do_reset();
    place(5'd3, 5'd2, 1'b1);
    frames(119);
    cyc(1'b1, 1'b1, 5'd6, 5'd6, 4'b0000, 1'b1);
    idle();
    n_checks++; if (bomb_exist !== 4'b0010 || bomb_exploded !== 4'b0000 || active_count !== 4'd1) begin n_fail++; $display("FAIL coincide got exist=%b expl=%b count=%0d required 0010/0000/1", bomb_exist, bomb_exploded, active_count); end
    n_checks++; if (xof(1) !== 11'd192 || yof(1) !== 11'd192 || xof(0) !== 11'd1000) begin n_fail++; $display("FAIL coincide_xy got x1=%0d y1=%0d x0=%0d required 192,192,1000", xof(1), yof(1), xof(0)); end
    frames(89);
    idle();
    n_checks++; if (bomb_exist !== 4'b0010) begin n_fail++; $display("FAIL coincide_fuse_len got exist=%b required=0010", bomb_exist); end
    frames(1);
    idle();
    n_checks++; if (bomb_exploded !== 4'b0010) begin n_fail++; $display("FAIL coincide_expire got expl=%b required=0010", bomb_exploded); end
  endtask

  task automatic test_chain();
    do_reset();
    place(5'd3, 5'd2, 1'b1);
    place(5'd5, 5'd2, 1'b1);
    place(5'd9, 5'd2, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 4'b0001, 1'b0);
    idle();
    n_checks++; if (bomb_exploded !== 4'b0001) begin n_fail++; $display("FAIL chain_first got expl=%b required=0001", bomb_exploded); end
    idle();
    idle();
`ifdef BOMB_CHAIN_REACTION_EN
    n_checks++; if (bomb_exploded !== 4'b0011 || bomb_exist !== 4'b0100) begin n_fail++; $display("FAIL chain_hop got expl=%b exist=%b required 0011/0100", bomb_exploded, bomb_exist); end
`else
    n_checks++; if (bomb_exploded !== 4'b0001 || bomb_exist !== 4'b0110) begin n_fail++; $display("FAIL chain_off got expl=%b exist=%b required 0001/0110", bomb_exploded, bomb_exist); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    place(5'd2, 5'd2, 1'b1);
    #1;
    resetN = 1'b0;
    exp_q.delete();
    #1;
    n_checks++; if ({place_ack, place_nack} !== 2'b00) begin n_fail++; $display("FAIL reset_mid_ack got=%b required=00", {place_ack, place_nack}); end
    do_reset();
    idle();
    n_checks++; if (bomb_exist !== 4'b0000 || active_count !== 4'd0) begin n_fail++; $display("FAIL reset_mid_state got exist=%b count=%0d required 0000/0", bomb_exist, active_count); end
    place(5'd2, 5'd2, 1'b1);
    idle();
    n_checks++; if (bomb_exist !== 4'b0001) begin n_fail++; $display("FAIL reset_mid_replace got exist=%b required=0001", bomb_exist); end
  endtask

  task automatic test_drain();
    idle();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain got %0d outstanding required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_place_and_expire();
    test_full_and_dup();
    test_detonate();
    test_place_on_expiry();
    test_chain();
    test_reset_mid();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
